// File: rtl/debounce_pulse.sv
// debounce_pulse: two-flop synchronizer followed by a four-state debounce FSM.
// A new input level is accepted only after DEBOUNCE_CYCLES consecutive matching
// synchronized samples; each accepted transition produces a one-cycle strobe.
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } state_t;

    // Last count value of a qualification window; reaching it with a matching
    // sample accepts the new level, so cnt stays within 0 .. DEBOUNCE_CYCLES-1.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync1_reg;
    logic                 sync2_reg;
    state_t               state_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 level_reg;
    logic                 rise_pulse_reg;
    logic                 fall_pulse_reg;

    // Bring the raw button into the clock domain; only sync2 is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce FSM with registered level and transition strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= LOW;
            cnt_reg        <= '0;
            level_reg      <= 1'b0;
            rise_pulse_reg <= 1'b0;
            fall_pulse_reg <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed by an accepted transition.
            rise_pulse_reg <= 1'b0;
            fall_pulse_reg <= 1'b0;
            case (state_reg)
                LOW: begin
                    if (sync2_reg) begin
                        state_reg <= CHK_HIGH;
                        cnt_reg   <= '0;
                    end
                end
                CHK_HIGH: begin
                    if (!sync2_reg) begin
                        // Bounce back: abandon this qualification silently.
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg      <= HIGH;
                        cnt_reg        <= '0;
                        level_reg      <= 1'b1;
                        rise_pulse_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!sync2_reg) begin
                        state_reg <= CHK_LOW;
                        cnt_reg   <= '0;
                    end
                end
                CHK_LOW: begin
                    if (sync2_reg) begin
                        // Bounce back: the level never left HIGH.
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg      <= LOW;
                        cnt_reg        <= '0;
                        level_reg      <= 1'b0;
                        fall_pulse_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= LOW;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end
            endcase
        end
    end

    assign level      = level_reg;
    assign rise_pulse = rise_pulse_reg;
    assign fall_pulse = fall_pulse_reg;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse: a vector table for the main behaviour
// plus hand-written sequences for asynchronous reset and DEBOUNCE_CYCLES=1.
module tb_debounce_pulse;

    logic clk;
    logic rst;
    logic btn_in;
    logic btn1;
    logic level, rise_pulse, fall_pulse;
    logic level1, rise1, fall1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       btn;
        logic [2:0] exp;   // {level, rise_pulse, fall_pulse}
    } vec_t;

    vec_t vec_q[$];

    debounce_pulse #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
    );

    debounce_pulse #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .btn_in(btn1),
        .level(level1), .rise_pulse(rise1), .fall_pulse(fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int n, input logic r, input logic b, input logic [2:0] e);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.rst = r;
            v.btn = b;
            v.exp = e;
            vec_q.push_back(v);
        end
    endtask

    task automatic compare(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {level,rise,fall}=%b expected %b", name, got, exp);
        end
    endtask

    // sel=0 observes the default instance, sel=1 the DEBOUNCE_CYCLES=1 instance.
    task automatic tick_check(input string name, input bit sel, input logic [2:0] exp);
        @(posedge clk);
        #1;
        if (sel) compare(name, {level1, rise1, fall1}, exp);
        else     compare(name, {level, rise_pulse, fall_pulse}, exp);
    endtask

    initial begin
        rst    = 1'b0;
        btn_in = 1'b0;
        btn1   = 1'b0;

        // Reset held with button pressed, then released: fresh qualification.
        add(2, 1'b0, 1'b1, 3'b000);
        add(6, 1'b1, 1'b1, 3'b000);
        add(1, 1'b1, 1'b1, 3'b110);
        add(5, 1'b1, 1'b1, 3'b100);
        // Clean release from HIGH: fall strobe at edge 7.
        add(6, 1'b1, 1'b0, 3'b100);
        add(1, 1'b1, 1'b0, 3'b001);
        add(3, 1'b1, 1'b0, 3'b000);
        // Clean press held 12 cycles.
        add(6, 1'b1, 1'b1, 3'b000);
        add(1, 1'b1, 1'b1, 3'b110);
        add(5, 1'b1, 1'b1, 3'b100);
        // Two-cycle low glitch while HIGH: level holds, no strobe.
        add(2, 1'b1, 1'b0, 3'b100);
        add(6, 1'b1, 1'b1, 3'b100);
        // Release back to LOW.
        add(6, 1'b1, 1'b0, 3'b100);
        add(1, 1'b1, 1'b0, 3'b001);
        add(3, 1'b1, 1'b0, 3'b000);
        // Three-cycle high glitch: never accepted.
        add(3, 1'b1, 1'b1, 3'b000);
        add(7, 1'b1, 1'b0, 3'b000);
        // Bounce every 2 cycles for 12 cycles, then held high.
        for (int k = 0; k < 3; k++) begin
            add(2, 1'b1, 1'b1, 3'b000);
            add(2, 1'b1, 1'b0, 3'b000);
        end
        add(6, 1'b1, 1'b1, 3'b000);
        add(1, 1'b1, 1'b1, 3'b110);
        add(3, 1'b1, 1'b1, 3'b100);
        // Return to LOW for the hand-written sequences.
        add(6, 1'b1, 1'b0, 3'b100);
        add(1, 1'b1, 1'b0, 3'b001);
        add(3, 1'b1, 1'b0, 3'b000);

        // Initial reset, checked once while asserted.
        repeat (3) @(posedge clk);
        #1;
        compare("reset_state", {level, rise_pulse, fall_pulse}, 3'b000);

        foreach (vec_q[i]) begin
            @(negedge clk);
            rst    = vec_q[i].rst;
            btn_in = vec_q[i].btn;
            @(posedge clk);
            #1;
            compare($sformatf("vec%0d", i), {level, rise_pulse, fall_pulse}, vec_q[i].exp);
            if (rise_pulse && fall_pulse) begin
                checks++;
                errors++;
                $display("FAIL both_pulses vec%0d: got rise=1 fall=1 expected not both", i);
            end
        end

        // Reset mid-qualification (CHK_HIGH, cnt=2) then held press re-qualifies.
        btn_in = 1'b1;
        for (int e = 1; e <= 5; e++) tick_check($sformatf("midchk_e%0d", e), 1'b0, 3'b000);
        #2;
        rst = 1'b0;
        #1;
        compare("midchk_async", {level, rise_pulse, fall_pulse}, 3'b000);
        tick_check("midchk_in_reset", 1'b0, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 6; e++) tick_check($sformatf("after_rst_e%0d", e), 1'b0, 3'b000);
        tick_check("after_rst_rise", 1'b0, 3'b110);
        tick_check("after_rst_hold", 1'b0, 3'b100);

        // Reset from HIGH must clear level before the next clock edge, no fall strobe.
        #2;
        rst    = 1'b0;
        btn_in = 1'b0;
        #1;
        compare("high_async_rst", {level, rise_pulse, fall_pulse}, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) tick_check($sformatf("rst_exit_e%0d", e), 1'b0, 3'b000);

        // DEBOUNCE_CYCLES=1: accept after one matching CHK sample (edge 4).
        btn1 = 1'b1;
        for (int e = 1; e <= 3; e++) tick_check($sformatf("n1_press_e%0d", e), 1'b1, 3'b000);
        tick_check("n1_rise", 1'b1, 3'b110);
        tick_check("n1_high", 1'b1, 3'b100);
        btn1 = 1'b0;
        for (int e = 1; e <= 3; e++) tick_check($sformatf("n1_rel_e%0d", e), 1'b1, 3'b100);
        tick_check("n1_fall", 1'b1, 3'b001);
        tick_check("n1_low", 1'b1, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a new level; legal range 1 .. 2^CNT_WIDTH-1.
REQ-002 Parameter: CNT_WIDTH, 16, stability counter width in bits.
REQ-003 Port: clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; rst=0 SHALL force reset state immediately, independent of clk.
REQ-005 Port: btn_in  input  1  raw asynchronous input (switch/button), may bounce.
REQ-006 Port: level  output  1  registered debounced level; drives the d input of the downstream flip-flop stage.
REQ-007 Port: rise_pulse  output  1  registered one-cycle strobe on each accepted 0->1 transition.
REQ-008 Port: fall_pulse  output  1  registered one-cycle strobe on each accepted 1->0 transition.

Function
REQ-009 btn_in SHALL pass through a 2-flop synchronizer (sync1, sync2); only sync2 SHALL feed the FSM.
REQ-010 FSM states SHALL be LOW, CHK_HIGH, HIGH, CHK_LOW, with a 2-bit state register.
REQ-011 LOW: sync2=1 -> CHK_HIGH with cnt cleared to 0; otherwise remain.
REQ-012 CHK_HIGH: sync2=0 -> LOW with cnt cleared, no pulse; sync2=1 and cnt=DEBOUNCE_CYCLES-1 -> HIGH; otherwise cnt increments by 1.
REQ-013 HIGH: sync2=0 -> CHK_LOW with cnt cleared; otherwise remain.
REQ-014 CHK_LOW: sync2=1 -> HIGH with cnt cleared, no pulse; sync2=0 and cnt=DEBOUNCE_CYCLES-1 -> LOW; otherwise cnt increments by 1.
REQ-015 level SHALL be 1 in HIGH and CHK_LOW and 0 in LOW and CHK_HIGH, registered and updated on the same edge as the state change.
REQ-016 rise_pulse SHALL be 1 for exactly the one cycle following the CHK_HIGH->HIGH edge; fall_pulse likewise for CHK_LOW->LOW; both 0 at all other times.
REQ-017 rise_pulse and fall_pulse SHALL never be 1 in the same cycle.
REQ-018 Latency: for btn_in first sampled high at edge 1 and held, level and rise_pulse SHALL rise at edge DEBOUNCE_CYCLES+3 (edge 7 at default); falling edge symmetric.
REQ-019 Any sample mismatch during a CHK state SHALL restart qualification from the next transition; cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-020 DEBOUNCE_CYCLES=1 SHALL accept a level after one matching sample in the CHK state (latency 4 edges).

Reset
REQ-021 rst=0 SHALL asynchronously set sync1=0, sync2=0, cnt=0, state=LOW, level=0, rise_pulse=0, fall_pulse=0.
REQ-022 Reset asserted mid-qualification or with btn_in=1 SHALL discard all progress; no pulse SHALL be emitted on reset entry or exit.
REQ-023 After rst returns to 1, a held btn_in=1 SHALL be qualified as a fresh rising transition (rise_pulse at edge DEBOUNCE_CYCLES+3 counted from the first edge after release).

Verification (DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-024 Reset: rst=0 with btn_in=1 for 20 ns -> level=0, rise_pulse=0, fall_pulse=0 throughout; after rst=1, rise_pulse high for one cycle at edge 7, level=1 thereafter.
REQ-025 Clean press: btn_in 0->1, held 12 cycles -> exactly one rise_pulse at edge 7, level=1 from edge 7, fall_pulse=0.
REQ-026 Glitch: btn_in=1 for 3 cycles then 0 -> level stays 0, no pulses at any time.
REQ-027 Bounce: btn_in toggling every 2 cycles for 12 cycles, then held 1 -> exactly one rise_pulse, 7 edges after the final 0->1 transition.
REQ-028 Release: from HIGH, btn_in 1->0 held -> exactly one fall_pulse at edge 7, level=0 from edge 7; a 2-cycle low glitch instead -> level stays 1, no pulse.
REQ-029 Reset mid-check: rst=0 asynchronously while in CHK_HIGH with cnt=2 -> outputs 0 immediately (before next clk edge), and no pulse for 3 edges after rst=1.
